mc_ctrl_gen: RTL and testbench

Parametrised multi-cycle MIPS control unit, successor to the fixed five-beat controller in the multi-cycle CPU top. It sequences fetch/decode/execute/memory/write-back for R-type, lw, sw, beq, bne, j and addi. It adds a memory ready handshake, a retired-instruction counter of configurable width and an illegal-opcode flag. It drives the existing pc, alu, regs and memory blocks, and its `beat` output feeds the debug display.

---
 rtl/mc_ctrl_gen_if.sv | 32 +++
 rtl/mc_ctrl_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_ctrl_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_gen_if.sv
// Controller-to-datapath bundle for mc_ctrl_gen: opcode and memory handshake in,
// multi-cycle datapath strobes and selects out.
interface mc_ctrl_gen_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       RegWrite;
   logic       PCWrite;
   logic       IRWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       ALUSrcA;
   logic       BranchNE;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;

   modport master (
      input  opcode, mem_ready,
      output RegWrite, PCWrite, IRWrite, PCWriteCond, IorD, MemRead, MemWrite,
             MemtoReg, RegDst, ALUSrcA, BranchNE, ALUSrcB, ALUOp, PCSource
   );

   modport slave (
      output opcode, mem_ready,
      input  RegWrite, PCWrite, IRWrite, PCWriteCond, IorD, MemRead, MemWrite,
             MemtoReg, RegDst, ALUSrcA, BranchNE, ALUSrcB, ALUOp, PCSource
   );
endinterface

// File: rtl/mc_ctrl_gen.sv
// Multi-cycle MIPS control unit (R, lw, sw, beq, bne, j, addi) with retired-instruction
// counter and illegal-opcode pulse. Define MC_MEMWAIT_EN to stall memory states on mem_ready.
module mc_ctrl_gen #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 255
) (
   input  logic               clk_cpu,
   input  logic               rst_cpu,
   mc_ctrl_gen_if.master      bus,
   output logic [3:0]         state,
   output logic [4:0]         beat,
   output logic [CNT_W-1:0]   instr_cnt,
   output logic               illegal_op,
   output logic               mem_timeout
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold;
   logic             legal_op;
   logic             retire;

   assign legal_op = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};

`ifdef MC_MEMWAIT_EN
   localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;

   assign hold = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR)
                 && !bus.mem_ready;

   // Saturating count of consecutive stalled cycles; any advance clears it
   always_comb begin
      wait_d    = '0;
      timeout_d = timeout_q;
      if (hold) begin
         wait_d = (wait_q == WAIT_W'(WAIT_MAX)) ? wait_q : wait_q + WAIT_W'(1);
         if (WAIT_MAX != 0 && wait_d == WAIT_W'(WAIT_MAX)) timeout_d = 1'b1;
      end
   end

   assign mem_timeout = timeout_q;
`else
   logic unused_mem_ready;

   assign hold             = 1'b0;
   assign unused_mem_ready = bus.mem_ready;
   assign mem_timeout      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (!hold) begin
         case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  OP_R:          state_d = S_EXEC;
                  OP_LW, OP_SW:  state_d = S_MEMADDR;
                  OP_BEQ, OP_BNE: state_d = S_BRANCH;
                  OP_J:          state_d = S_JUMP;
                  OP_ADDI:       state_d = S_ADDIEX;
                  default:       state_d = S_FETCH;
               endcase
            end
            S_MEMADDR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_RWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
         endcase
      end
   end

   // Every return to fetch from another state retires exactly one instruction
   assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);
   assign cnt_d  = cnt_q + CNT_W'(retire);

   always_ff @(posedge clk_cpu or posedge rst_cpu) begin
      if (rst_cpu) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
`ifdef MC_MEMWAIT_EN
         wait_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
`ifdef MC_MEMWAIT_EN
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   logic       reg_write, pc_write, ir_write, pc_write_cond, ior_d, mem_read, mem_write;
   logic       mem_to_reg, reg_dst, alu_src_a, branch_ne;
   logic [1:0] alu_src_b, alu_op, pc_source;

   // Strobes follow the registered state and are held low for as long as reset is high
   always_comb begin
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      pc_write_cond = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      branch_ne     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      if (!rst_cpu) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_write  = !hold;
               pc_write  = !hold;
               alu_src_b = 2'b01;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               ior_d    = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               ior_d     = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_RWB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               branch_ne     = (bus.opcode == OP_BNE);
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_ADDIWB:  reg_write = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.RegWrite    = reg_write;
   assign bus.PCWrite     = pc_write;
   assign bus.IRWrite     = ir_write;
   assign bus.PCWriteCond = pc_write_cond;
   assign bus.IorD        = ior_d;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.RegDst      = reg_dst;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.BranchNE    = branch_ne;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.ALUOp       = alu_op;
   assign bus.PCSource    = pc_source;

   // Display phase: fetch, decode, execute/address, memory/write, load write-back
   always_comb begin
      case (state_q)
         S_FETCH:                                         beat = 5'b00001;
         S_DECODE:                                        beat = 5'b00010;
         S_MEMADDR, S_EXEC, S_BRANCH, S_JUMP, S_ADDIEX:   beat = 5'b00100;
         S_MEMRD, S_MEMWR, S_RWB, S_ADDIWB:               beat = 5'b01000;
         S_MEMWB:                                         beat = 5'b10000;
         default:                                         beat = 5'b00001;
      endcase
   end

   assign state      = state_q;
   assign instr_cnt  = cnt_q;
   assign illegal_op = !rst_cpu && (state_q == S_DECODE) && !legal_op;

endmodule

// File: tb/tb_mc_ctrl_gen.sv
// Bench for mc_ctrl_gen: instruction-path model checked every cycle, plus directed literal pins.
module tb_mc_ctrl_gen;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 2;
`ifdef MC_MEMWAIT_EN
   localparam bit MEMWAIT = 1'b1;
`else
   localparam bit MEMWAIT = 1'b0;
`endif

   localparam logic [16:0] C_RW  = 17'h10000, C_PCW = 17'h08000, C_IRW = 17'h04000;
   localparam logic [16:0] C_PWC = 17'h02000, C_IOD = 17'h01000, C_MR  = 17'h00800;
   localparam logic [16:0] C_MW  = 17'h00400, C_M2R = 17'h00200, C_RD  = 17'h00100;
   localparam logic [16:0] C_SA  = 17'h00080, SB_01 = 17'h00010, SB_10 = 17'h00020;
   localparam logic [16:0] SB_11 = 17'h00030, AO_01 = 17'h00004, AO_10 = 17'h00008;
   localparam logic [16:0] PS_01 = 17'h00001, PS_10 = 17'h00002;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef logic [3:0] path_t [$];

   logic               clk_cpu;
   logic               rst_cpu;
   logic [3:0]         state;
   logic [4:0]         beat;
   logic [CNT_W-1:0]   instr_cnt;
   logic               illegal_op;
   logic               mem_timeout;
   logic [16:0]        dut_ctrl;
   logic [17:0]        probe;

   int checks   = 0;
   int failures = 0;

   logic [3:0] m_state = 4'd0;
   path_t      m_path;
   int         m_cnt  = 0;
   int         m_wait = 0;
   logic       m_to   = 1'b0;

   logic [5:0] soakOps [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, 6'h3F, 6'h11};

   mc_ctrl_gen_if bus ();

   mc_ctrl_gen #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk_cpu     (clk_cpu),
      .rst_cpu     (rst_cpu),
      .bus         (bus),
      .state       (state),
      .beat        (beat),
      .instr_cnt   (instr_cnt),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout)
   );

   assign dut_ctrl = {bus.RegWrite, bus.PCWrite, bus.IRWrite, bus.PCWriteCond, bus.IorD,
                      bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegDst, bus.ALUSrcA,
                      bus.BranchNE, bus.ALUSrcB, bus.ALUOp, bus.PCSource};

   initial begin
      clk_cpu = 1'b0;
      forever #5 clk_cpu = ~clk_cpu;
   end

   function automatic logic isLegal(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
   endfunction

   // States an instruction walks through after decode; empty means straight back to fetch
   function automatic path_t pathFor(input logic [5:0] op);
      path_t p;
      case (op)
         OP_R:           begin p.push_back(4'd6); p.push_back(4'd7); end
         OP_LW:          begin p.push_back(4'd2); p.push_back(4'd3); p.push_back(4'd4); end
         OP_SW:          begin p.push_back(4'd2); p.push_back(4'd5); end
         OP_BEQ, OP_BNE: p.push_back(4'd8);
         OP_J:           p.push_back(4'd9);
         OP_ADDI:        begin p.push_back(4'd10); p.push_back(4'd11); end
         default: ;
      endcase
      return p;
   endfunction

   function automatic logic [16:0] ctrlFor(input logic [3:0] st);
      case (st)
         4'd0:  return C_PCW | C_IRW | C_MR | SB_01;
         4'd1:  return SB_11;
         4'd2:  return C_SA | SB_10;
         4'd3:  return C_MR | C_IOD;
         4'd4:  return C_RW | C_M2R;
         4'd5:  return C_MW | C_IOD;
         4'd6:  return C_SA | AO_10;
         4'd7:  return C_RD | C_RW;
         4'd8:  return C_SA | AO_01 | C_PWC | PS_01;
         4'd9:  return C_PCW | PS_10;
         4'd10: return C_SA | SB_10;
         4'd11: return C_RW;
         default: return 17'h0;
      endcase
   endfunction

   function automatic logic [4:0] beatFor(input logic [3:0] st);
      case (st)
         4'd0: return 5'b00001;
         4'd1: return 5'b00010;
         4'd4: return 5'b10000;
         4'd3, 4'd5, 4'd7, 4'd11: return 5'b01000;
         default: return 5'b00100;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: steps through each instruction's state path, stalls and counts retirements
   initial forever begin
      @(posedge clk_cpu or posedge rst_cpu);
      if (rst_cpu) begin
         m_state = 4'd0;
         m_path.delete();
         m_cnt   = 0;
         m_wait  = 0;
         m_to    = 1'b0;
      end else if (MEMWAIT && (m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5)
                   && !bus.mem_ready) begin
         if (m_wait < WAIT_MAX) m_wait++;
         if (WAIT_MAX != 0 && m_wait == WAIT_MAX) m_to = 1'b1;
      end else begin
         m_wait = 0;
         if (m_state == 4'd1) m_path = pathFor(bus.opcode);
         if (m_state == 4'd0) m_state = 4'd1;
         else if (m_path.size() == 0) begin
            m_state = 4'd0;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
         end else m_state = m_path.pop_front();
      end
   end

   // Compare process: every cycle, away from the active edge
   initial forever begin
      logic [16:0] ec;
      @(negedge clk_cpu);
      ec = rst_cpu ? 17'h0 : ctrlFor(m_state);
      if (!rst_cpu && m_state == 4'd8) ec[6] = (bus.opcode == OP_BNE);
      if (!rst_cpu && MEMWAIT && m_state == 4'd0 && !bus.mem_ready) ec[15:14] = 2'b00;
      checkOutput("ctrl", 32'(dut_ctrl), 32'(ec));
      checkOutput("state", 32'(state), 32'(m_state));
      checkOutput("beat", 32'(beat), 32'(beatFor(m_state)));
      checkOutput("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
      checkOutput("illegal_op", 32'(illegal_op),
                  32'(!rst_cpu && m_state == 4'd1 && !isLegal(bus.opcode)));
      checkOutput("mem_timeout", 32'(mem_timeout), 32'(m_to));
   end

   // Runs one instruction from fetch, pinning the state path and sampling controls at one step
   task automatic applyStimulus(input logic [5:0] op, input logic [23:0] seq, input int len,
                                input int probeK, output logic [17:0] pr);
      bus.opcode = op;
      pr = '0;
      for (int k = 0; k < len; k++) begin
         if (k > 0) @(negedge clk_cpu);
         #1;
         checkOutput($sformatf("path op=%b step%0d", op, k), 32'(state), 32'(seq[4*k +: 4]));
         if (k == probeK) pr = {illegal_op, dut_ctrl};
      end
      @(negedge clk_cpu);
      #1;
      checkOutput($sformatf("path op=%b end", op), 32'(state), 32'd0);
   endtask

   initial begin
      rst_cpu       = 1'b1;
      bus.opcode    = OP_R;
      bus.mem_ready = 1'b1;
      repeat (3) @(negedge clk_cpu);
      #1;
      checkOutput("reset state", 32'(state), 32'd0);
      checkOutput("reset beat", 32'(beat), 32'h01);
      checkOutput("reset strobes", 32'(dut_ctrl), 32'd0);
      rst_cpu = 1'b0;
      #1;
      checkOutput("fetch strobes released", 32'(dut_ctrl), 32'h0C810);

      applyStimulus(OP_R, 24'h007610, 4, 3, probe);
      checkOutput("R S7 controls", 32'(probe), 32'h10100);
      checkOutput("cnt after R", 32'(instr_cnt), 32'd1);

      applyStimulus(OP_LW, 24'h043210, 5, 4, probe);
      checkOutput("lw S4 controls", 32'(probe), 32'h10200);
      applyStimulus(OP_SW, 24'h005210, 4, 3, probe);
      checkOutput("sw S5 controls", 32'(probe), 32'h01400);
      checkOutput("cnt after lw/sw", 32'(instr_cnt), 32'd3);

      applyStimulus(OP_BNE, 24'h000810, 3, 2, probe);
      checkOutput("bne S8 controls", 32'(probe), 32'h020C5);
      applyStimulus(OP_BEQ, 24'h000810, 3, 2, probe);
      checkOutput("beq S8 controls", 32'(probe), 32'h02085);
      applyStimulus(OP_J, 24'h000910, 3, 2, probe);
      checkOutput("j S9 controls", 32'(probe), 32'h08002);
      applyStimulus(6'h3F, 24'h000010, 2, 1, probe);
      checkOutput("illegal S1 pulse", 32'(probe), 32'h20030);
      checkOutput("cnt after illegal", 32'(instr_cnt), 32'd7);

      for (int i = 0; i < 17; i++) applyStimulus(OP_J, 24'h000910, 3, 0, probe);
      checkOutput("cnt wrap after 17 more", 32'(instr_cnt), 32'd8);

      applyStimulus(OP_ADDI, 24'h00BA10, 4, 2, probe);
      checkOutput("addi S10 controls", 32'(probe), 32'h000A0);
      checkOutput("cnt after addi", 32'(instr_cnt), 32'd9);

      // Reset arriving in the middle of a store
      bus.opcode = OP_SW;
      repeat (3) begin
         @(negedge clk_cpu);
         #1;
      end
      checkOutput("sw reached S5", 32'(state), 32'd5);
      checkOutput("MemWrite in S5", 32'(bus.MemWrite), 32'd1);
      rst_cpu = 1'b1;
      #1;
      checkOutput("abort state", 32'(state), 32'd0);
      checkOutput("abort strobes", 32'(dut_ctrl), 32'd0);
      checkOutput("abort cnt", 32'(instr_cnt), 32'd0);
      @(negedge clk_cpu);
      #1;
      rst_cpu = 1'b0;

`ifdef MC_MEMWAIT_EN
      bus.opcode = OP_LW;
      #1;
      repeat (3) begin
         @(negedge clk_cpu);
         #1;
      end
      checkOutput("lw reached S3", 32'(state), 32'd3);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_cpu);
         #1;
         checkOutput($sformatf("S3 hold %0d", i), 32'(state), 32'd3);
         checkOutput($sformatf("S3 hold strobes %0d", i), 32'(dut_ctrl), 32'h01800);
      end
      checkOutput("timeout set", 32'(mem_timeout), 32'd1);
      bus.mem_ready = 1'b1;
      @(negedge clk_cpu);
      #1;
      checkOutput("S3 released to S4", 32'(state), 32'd4);
      @(negedge clk_cpu);
      #1;
      applyStimulus(OP_J, 24'h000910, 3, 0, probe);
      checkOutput("timeout sticky", 32'(mem_timeout), 32'd1);
`else
      bus.mem_ready = 1'b0;
      applyStimulus(OP_LW, 24'h043210, 5, 3, probe);
      checkOutput("lw S3 ignores ready", 32'(probe), 32'h01800);
      checkOutput("timeout tied low", 32'(mem_timeout), 32'd0);
      bus.mem_ready = 1'b1;
`endif

      // Random mix of opcodes and ready patterns, checked by the model
      for (int c = 0; c < 150; c++) begin
         @(negedge clk_cpu);
         #1;
         if (m_state == 4'd0) bus.opcode = soakOps[$urandom_range(0, 8)];
         bus.mem_ready = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk_cpu);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
